key_expand_seq: RTL and testbench
=================================

# key_expand_seq

Sequential AES-128 key-expansion unit that turns one 128-bit cipher key into the 11 round keys (round 0 through round 10), one per handshake, on the fly. It sits directly upstream of the round datapath. Round key k is delivered to the round-key input of the round stage for round k, and round key 10 is delivered to the final round without MixColumns. It replaces a precomputed 1408-bit key array with a single 128-bit register plus one combinational step.

## Interface
Parameters:
- none. AES-128 only; 10 rounds are fixed.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  pulse that begins an expansion of key_in; honoured only in IDLE.
- key_in  input  128  cipher key; sampled only on an accepted start. Bits [127:120] are byte 0, and w0 = key_in[127:96].
- rk_ready  input  1  the downstream round stage can consume rk_out this cycle.
- rk_valid  output  1  rk_out and rk_idx hold a valid round key.
- rk_out  output  128  current round key, same byte order as key_in.
- rk_idx  output  4  index of the current round key, 0..10.
- busy  output  1  high from the cycle after an accepted start until the cycle round key 10 is accepted, inclusive.
- done  output  1  one-cycle pulse after round key 10 is accepted.

## Operation
- **States.** The FSM has two states, IDLE and EMIT. All outputs are registered.
- **Reset.** While rst_n=0 at a clock edge:
  - state goes to IDLE;
  - rk_valid=0, rk_out=0, rk_idx=0, busy=0, done=0;
  - the internal rcon register is set to 8'h01.
- **IDLE.** A start=1 at an edge causes the following:
  - the key register loads key_in;
  - rk_idx goes to 0, rcon to 8'h01;
  - rk_valid and busy go to 1;
  - state goes to EMIT.
- **EMIT, handshake.** A handshake is rk_valid & rk_ready at a clock edge.
  - With rk_idx < 10, the handshake loads the next round key, increments rk_idx, and advances rcon by xtime: doubling in GF(2^8), with 8'h80 → 8'h1b.
  - With rk_idx = 10, the handshake clears rk_valid and busy, pulses done for one cycle, and returns the FSM to IDLE. rk_out and rk_idx keep their last values.
- **Next-key function.** With the current key split as w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0};
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES forward S-box to each byte, using four byte S-box instances with the same table as sub_bytes.
- **Rcon sequence.** The rcon used to produce rounds 1..10 is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **Stall.** While rk_ready=0, rk_out, rk_idx and rk_valid hold stable. No key is skipped or repeated.
- **Boundary conditions.**
  - start while in EMIT is ignored and has no effect on the sequence.
  - start in the same cycle that done=1 is accepted, because the FSM is already in IDLE.
  - rk_ready while rk_valid=0 is ignored.
  - rst_n low during EMIT aborts the sequence. No done is issued, and all outputs take their reset values at that edge.

## Timing
- **Start latency.** start accepted at edge t → rk_valid=1, rk_idx=0, rk_out=key_in visible after edge t.
- **Per-key latency.** A handshake at edge n → the next key and index are visible after edge n. There is one cycle per key, with no bubbles while rk_ready=1.
- **Full-rate throughput.** With rk_ready held at 1, keys 0..10 occupy 11 consecutive cycles. done is high in the 12th cycle after start is accepted. busy is low from that cycle onward.
- **Critical path.** One S-box plus XOR chain per cycle; no pipelining inside the next-key step.

## Test plan
- **FIPS-197 full-rate run.** rst_n=0 for 2 cycles, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 → the following, with done one cycle after idx 10:
  - idx0 = key_in;
  - idx1 = a0fafe1788542cb123a339392a6c7605;
  - idx2 = f2c295f27a96b9435935807a7359f67f;
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- **Backpressure.** Same key, with rk_ready toggled pseudo-randomly (hold low up to 5 cycles) → an identical sequence of 11 keys in order. rk_out and rk_idx are stable whenever rk_valid=1 and rk_ready=0. done appears only after the idx 10 handshake.
- **Ignored start.** start pulses with key_in=000102030405060708090a0b0c0d0e0f while at idx 4 → the sequence continues with the original key, and rk_idx goes 5, 6, … unaffected.
- **Back-to-back.** Second start with key_in=000102030405060708090a0b0c0d0e0f, asserted in the done cycle → next cycle rk_idx=0, rk_out=000102030405060708090a0b0c0d0e0f. idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **Reset mid-operation.** rst_n=0 for one edge while at idx 6 → after that edge all outputs are 0, the FSM is in IDLE, and no done is issued. A new start then reproduces the FIPS-197 sequence from idx0, confirming rcon was reset to 01.

Source files
------------

// File: rtl/key_expand_seq.sv
// AES-128 key-expansion sequencer: holds one 128-bit round key and derives
// the next one on the fly. It emits round keys 0..10, one per handshake.
//
// Handshake: a round key transfers on any rising edge where rk_valid and
// rk_ready are both 1. While rk_valid=1 and rk_ready=0, rk_out and rk_idx
// hold steady. rk_ready is ignored while rk_valid=0.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward AES S-box, same table as sub_bytes.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Table lookup.
    always_comb begin
        y = SBOX[a];
    end
endmodule

module key_expand_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state, state_nx;
    logic [7:0]   rcon, rcon_nx;
    logic         rk_valid_nx, busy_nx, done_nx;
    logic [127:0] rk_out_nx;
    logic [3:0]   rk_idx_nx;

    // rk_out doubles as the key register; the next key is derived from it.
    logic [31:0]  w0, w1, w2, w3, rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_x2;

    assign {w0, w1, w2, w3} = rk_out;
    assign rot = {w3[23:0], w3[31:24]};

    aes_sbox u_sb0 (.a(rot[31:24]), .y(sub[31:24]));
    aes_sbox u_sb1 (.a(rot[23:16]), .y(sub[23:16]));
    aes_sbox u_sb2 (.a(rot[15:8]),  .y(sub[15:8]));
    aes_sbox u_sb3 (.a(rot[7:0]),   .y(sub[7:0]));

    // One-step key schedule: S-box plus XOR chain, no pipelining.
    always_comb begin
        t        = sub ^ {rcon, 24'h0};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
        rcon_x2  = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // Next-state and registered-output logic; everything holds by default.
    always_comb begin
        state_nx    = state;
        rcon_nx     = rcon;
        rk_valid_nx = rk_valid;
        rk_out_nx   = rk_out;
        rk_idx_nx   = rk_idx;
        busy_nx     = busy;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rk_out_nx   = key_in;
                    rk_idx_nx   = 4'd0;
                    rcon_nx     = 8'h01;
                    rk_valid_nx = 1'b1;
                    busy_nx     = 1'b1;
                    state_nx    = EMIT;
                end
            end
            EMIT: begin
                if (rk_valid && rk_ready) begin
                    if (rk_idx == 4'd10) begin
                        rk_valid_nx = 1'b0;
                        busy_nx     = 1'b0;
                        done_nx     = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        rk_out_nx = next_key;
                        rk_idx_nx = rk_idx + 4'd1;
                        rcon_nx   = rcon_x2;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rcon     <= 8'h01;
            rk_valid <= 1'b0;
            rk_out   <= 128'h0;
            rk_idx   <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            rcon     <= rcon_nx;
            rk_valid <= rk_valid_nx;
            rk_out   <= rk_out_nx;
            rk_idx   <= rk_idx_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: random backpressure and keys, expected round
// keys from a word-array key schedule with an S-box derived from GF(2^8)
// inversion, checked by a negedge monitor against a scoreboard queue.

module tb_key_expand_seq;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk, rst_n, start, rk_ready;
    logic [127:0] key_in;
    logic         rk_valid, busy, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    int n_checks = 0;
    int n_errors = 0;
    logic [131:0] exp_q[$];

    key_expand_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .rk_ready(rk_ready), .rk_valid(rk_valid), .rk_out(rk_out),
        .rk_idx(rk_idx), .busy(busy), .done(done)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: GF(2^8) arithmetic and FIPS-197 word schedule.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] s, input int n);
        logic [15:0] d = {s, s};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] base = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            base = gmul(base, base);
            inv  = gmul(inv, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    task automatic push_expected(input logic [127:0] key);
        logic [31:0]  w[44];
        logic [31:0]  temp;
        logic [7:0]   rc;
        logic [127:0] rk[11];
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        // Published vectors take precedence for the known keys.
        if (key == FIPS_KEY) begin
            rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
            rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        end
        if (key == ALT_KEY) rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int k = 0; k < 11; k++) exp_q.push_back({4'(k), rk[k]});
    endtask

    // Monitor: handshakes pop the scoreboard; done, busy and stall checked.
    logic         done_pending = 1'b0;
    logic         prev_stall   = 1'b0;
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    logic [131:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_pending = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            chk("done", 128'(done), 128'(done_pending));
            done_pending = 1'b0;
            chk("busy", 128'(busy), 128'(rk_valid));
            if (prev_stall) begin
                chk("stall_valid", 128'(rk_valid), 128'(1));
                chk("stall_out", rk_out, prev_out);
                chk("stall_idx", 128'(rk_idx), 128'(prev_idx));
            end
            if (rk_valid && rk_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_key: got idx %0d key %h expected no key", rk_idx, rk_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rk_idx", 128'(rk_idx), 128'(e[131:128]));
                    chk("rk_out", rk_out, e[127:0]);
                    if (e[131:128] == 4'd10) done_pending = 1'b1;
                end
            end
            prev_stall = rk_valid && !rk_ready;
            prev_out   = rk_out;
            prev_idx   = rk_idx;
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, "_out"}, rk_out, 128'h0);
        chk({tag, "_idx"}, 128'(rk_idx), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        start = 1'b0;
        rk_ready = 1'b0;
        repeat (n) tick();
        exp_q.delete();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        push_expected(key);
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("start_valid", 128'(rk_valid), 128'(1));
        chk("start_idx", 128'(rk_idx), 128'(0));
        chk("start_out", rk_out, key);
        chk("start_busy", 128'(busy), 128'(1));
    endtask

    // Runs until done, optionally with backpressure, a stray start at
    // inject_idx, or a reset pulse at abort_idx.
    task automatic run(input bit bp, input int inject_idx, input int abort_idx, output int cycles);
        int low = 0;
        bit injected = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            start = 1'b0;
            if (abort_idx >= 0 && rk_valid && int'(rk_idx) == abort_idx) begin
                rst_n = 1'b0;
                rk_ready = 1'($urandom_range(0, 1));
                tick();
                rst_n = 1'b1;
                exp_q.delete();
                chk_reset_outputs("abort");
                return;
            end
            if (low > 0) begin
                rk_ready = 1'b0;
                low--;
            end else if (bp && $urandom_range(0, 2) == 0) begin
                rk_ready = 1'b0;
                low = int'($urandom_range(0, 4));
            end else begin
                rk_ready = 1'b1;
            end
            if (inject_idx >= 0 && !injected && rk_valid && int'(rk_idx) == inject_idx) begin
                start = 1'b1;
                key_in = ALT_KEY;
                injected = 1'b1;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        chk("run_done", 128'(done), 128'(1));
    endtask

    int cyc;

    // Test sequence.
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rk_ready = 1'b0;
        key_in = 128'h0;
        do_reset(2);

        // FIPS-197 vector at full rate, then ready with nothing valid.
        do_start(FIPS_KEY);
        run(1'b0, -1, -1, cyc);
        chk("fullrate_cycles", 128'(cyc), 128'(11));
        rk_ready = 1'b1;
        repeat (3) tick();
        chk("idle_valid", 128'(rk_valid), 128'(0));
        chk("idle_idx", 128'(rk_idx), 128'(10));
        chk("idle_out", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("idle_busy", 128'(busy), 128'(0));

        // Backpressure.
        do_start(FIPS_KEY);
        run(1'b1, -1, -1, cyc);

        // Start while emitting idx 4 must be ignored.
        do_start(FIPS_KEY);
        run(1'b1, 4, -1, cyc);

        // Back-to-back: second start in the done cycle.
        do_start(FIPS_KEY);
        run(1'b0, -1, -1, cyc);
        do_start(ALT_KEY);
        run(1'b0, -1, -1, cyc);
        chk("b2b_cycles", 128'(cyc), 128'(11));

        // Reset while at idx 6, then a clean FIPS run.
        do_start({$urandom, $urandom, $urandom, $urandom});
        run(1'b1, -1, 6, cyc);
        repeat (3) tick();
        chk("post_abort_done", 128'(done), 128'(0));
        chk("post_abort_valid", 128'(rk_valid), 128'(0));
        do_start(FIPS_KEY);
        run(1'b0, -1, -1, cyc);
        chk("post_abort_cycles", 128'(cyc), 128'(11));

        // Random keys, back-to-back, mixed backpressure.
        for (int i = 0; i < 6; i++) begin
            do_start({$urandom, $urandom, $urandom, $urandom});
            run(i % 3 != 0, -1, -1, cyc);
        end

        rk_ready = 1'b0;
        repeat (3) tick();
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
